seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential signed shift-subtract divider. It is the inverse-operation companion to the team's 8-bit shift-add multiplier.
- It uses the same switch/button style interface. The divisor is loaded from S with one control. The dividend is taken from S when run starts the operation.
- Quotient and remainder are held on output registers for the hex displays.
- One iteration per clock, under a small control FSM.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement)

Ports:
Clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
load_divisor  in  1  active-high; when in IDLE, latch S into divisor register
run  in  1  active-high; when in IDLE, latch S as dividend and start division
S  in  WIDTH  switch operand bus
Dval  out  WIDTH  current divisor register
Qval  out  WIDTH  signed quotient (truncated toward zero)
Rval  out  WIDTH  signed remainder (sign follows dividend)
busy  out  1  high while an operation is in progress
div_by_zero  out  1  sticky until next start; last op had divisor 0
overflow  out  1  sticky until next start; last op was -2^(WIDTH-1) / -1

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE; Dval, Qval, Rval=0; busy, div_by_zero, overflow=0; iteration counter=0.
- States: IDLE, PREP, ITER, FIX, HOLD.
- IDLE:
  - load_divisor=1: Dval<=S at that edge; run is ignored that cycle (load has priority).
  - Else run=1: latch dividend<=S; clear div_by_zero and overflow; go to PREP.
  - busy=0.
- PREP (1 cycle):
  - Compute unsigned magnitudes |dividend|, |divisor| in WIDTH bits (|-128|=128 fits unsigned).
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the WIDTH+1-bit partial remainder; counter=0.
  - Divisor==0: Qval<=all ones, Rval<=dividend, div_by_zero<=1, go to HOLD.
  - Else dividend==-2^(WIDTH-1) and divisor==-1: Qval<=8'h80, Rval<=0, overflow<=1, go to HOLD.
  - Otherwise go to ITER.
- ITER (exactly WIDTH cycles, counter 0..WIDTH-1), restoring algorithm:
  - Shift {rem, quo} left 1 and bring in the dividend MSB.
  - If rem >= |divisor|: rem -= |divisor| and quotient LSB=1; else LSB=0.
  - After counter==WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Qval <= sign_q ? -quo : quo.
  - Rval <= sign_r ? -rem : rem.
  - Go to HOLD.
- HOLD:
  - busy=0; outputs stable.
  - Stay while run=1; go to IDLE when run=0 (one operation per run assertion, no auto-restart).
- busy=1 in PREP, ITER, FIX.
- Qval/Rval change only on the PREP-exception edge or the FIX edge; they hold previous values during ITER.
- Latency: run sampled at edge 0 -> PREP; ITER on edges 2..9; FIX->HOLD at edge 10, with Qval/Rval valid after edge 10 (WIDTH+2 cycles). Exceptions are valid after edge 1.
- Changes to load_divisor or S while busy or in HOLD: ignored; Dval unchanged.
- Invariant (non-exception): dividend == Qval*Dval + Rval, |Rval| < |Dval|, Rval==0 or sign(Rval)==sign(dividend).

Test Plan:
- Basic: reset; load_divisor with S=8'h07; run with S=8'd100 -> after 10 cycles Qval=8'h0E, Rval=8'h02; busy high exactly cycles 1..10; overflow=0, div_by_zero=0.
- Signed: divisor 7, dividend -59 (8'hC5) -> Qval=8'hF8 (-8), Rval=8'hFD (-3). Divisor -7 (8'hF9), dividend 59 -> Qval=8'hF8, Rval=8'h03.
- Exceptions:
  - divisor 0, dividend 5 -> after 2 cycles Qval=8'hFF, Rval=8'h05, div_by_zero=1.
  - divisor 8'hFF, dividend 8'h80 -> Qval=8'h80, Rval=8'h00, overflow=1.
  - Next normal op clears both flags.
- Handshake:
  - Hold run=1 for 30 cycles -> exactly one operation, state stays HOLD.
  - Assert load_divisor with S=3 during ITER -> Dval unchanged.
  - load_divisor and run together in IDLE -> Dval updated, no start that cycle.
- Reset mid-op: assert reset at ITER counter=4 -> next cycle all outputs 0, busy=0, IDLE. A fresh run with divisor 0 (cleared) flags div_by_zero.
- Sweep: all dividend in [-128,127] x divisors {1,-1,2,-3,7,127,-128} -> invariant holds (excepting overflow case), latency 10 cycles each.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, with
// divide-by-zero and most-negative/-1 overflow handled up front in PREP.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load_divisor,
    input  logic             run,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Dval,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, HOLD} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;

    logic             start;
    logic             last_iter;
    logic             divisor_zero;
    logic             is_overflow;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign start        = (state == IDLE) && !load_divisor && run;
    assign last_iter    = (count == LAST_COUNT);
    assign divisor_zero = (Dval == '0);
    assign is_overflow  = (dividend == MOST_NEG) && (Dval == '1);

    // The stored remainder is always below |divisor|, so it fits in WIDTH bits;
    // only the shifted trial value needs the extra bit. The borrow out of the
    // trial subtraction is the "remainder < divisor" decision.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, mag_divisor};
    assign rem_ge    = ~rem_diff[WIDTH];

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = (divisor_zero || is_overflow) ? HOLD : ITER;
            ITER:    if (last_iter) next_state = FIX;
            FIX:     next_state = HOLD;
            HOLD:    if (!run) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == PREP) || (state == ITER) || (state == FIX);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            Dval        <= '0;
            Qval        <= '0;
            Rval        <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dividend    <= '0;
            quo         <= '0;
            mag_divisor <= '0;
            rem         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_divisor) begin
                        Dval <= S;
                    end else if (run) begin
                        dividend    <= S;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                PREP: begin
                    quo         <= magnitude(dividend);
                    mag_divisor <= magnitude(Dval);
                    sign_q      <= dividend[WIDTH-1] ^ Dval[WIDTH-1];
                    sign_r      <= dividend[WIDTH-1];
                    rem         <= '0;
                    count       <= '0;
                    if (divisor_zero) begin
                        Qval        <= '1;
                        Rval        <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (is_overflow) begin
                        Qval     <= MOST_NEG;
                        Rval     <= '0;
                        overflow <= 1'b1;
                    end
                end
                ITER: begin
                    rem   <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], rem_ge};
                    count <= count + CW'(1);
                end
                FIX: begin
                    Qval <= sign_q ? -quo : quo;
                    Rval <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule
